// File: rtl/overture_pkg.sv
// Shared definitions for the Overture fetch/execute sequencer: opcode classes,
// jump condition codes and the sequencer state encoding.
package overture_pkg;

    localparam logic [1:0] OP_IMM  = 2'b00;
    localparam logic [1:0] OP_CALC = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_COND = 2'b11;

    localparam logic [2:0] COND_NEVER  = 3'd0;
    localparam logic [2:0] COND_EQ0    = 3'd1;
    localparam logic [2:0] COND_LT0    = 3'd2;
    localparam logic [2:0] COND_LE0    = 3'd3;
    localparam logic [2:0] COND_ALWAYS = 3'd4;
    localparam logic [2:0] COND_NE0    = 3'd5;
    localparam logic [2:0] COND_GE0    = 3'd6;
    localparam logic [2:0] COND_GT0    = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        EXEC     = 2'd2,
        ALU_WAIT = 2'd3
    } state_e;

    function automatic logic [1:0] op_class(input logic [7:0] instr);
        return instr[7:6];
    endfunction

endpackage

// File: rtl/overture_cond_eval.sv
// Jump condition evaluator: decides whether a conditional jump is taken from
// the 3-bit condition code and the signed condition operand.
module overture_cond_eval
    import overture_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [7:0] val,
    output logic       take
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (val == 8'h00);
    assign is_neg  = val[7];

    // NOTE: take gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_NEVER:  take = 1'b0;
            COND_EQ0:    take = is_zero;
            COND_LT0:    take = is_neg;
            COND_LE0:    take = is_neg | is_zero;
            COND_ALWAYS: take = 1'b1;
            COND_NE0:    take = ~is_zero;
            COND_GE0:    take = ~is_neg;
            COND_GT0:    take = ~is_neg & ~is_zero;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_sequencer.sv
// Overture CPU fetch/execute sequencer: owns PC and IR, fetches over req/ack,
// issues one-cycle EXEC strobes and resolves conditional jumps via reg3/reg0.
module overture_sequencer
    import overture_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  ALU_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [7:0]          imem_data,
    input  logic [7:0]          reg0_val,
    input  logic [7:0]          reg3_val,
    output logic                imm_we,
    output logic [7:0]          imm_data,
    output logic                copy_we,
    output logic [2:0]          copy_src,
    output logic [2:0]          copy_dst,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                branch_taken,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          ir,
    output logic                busy,
    output logic                fault
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          ir_q;
    logic                fault_q;
    logic [CNT_W-1:0]    tmo_cnt_q;

    logic [CNT_W-1:0]    tmo_cnt_inc;
    logic [PC_WIDTH-1:0] jump_target;
    logic [1:0]          cls;
    logic                in_exec;
    logic                cond_take;

    overture_cond_eval u_cond (
        .cond (ir_q[2:0]),
        .val  (reg3_val),
        .take (cond_take)
    );

    assign cls         = op_class(ir_q);
    assign in_exec     = (state_q == EXEC);
    assign tmo_cnt_inc = tmo_cnt_q + 1'b1;
    assign jump_target = PC_WIDTH'(reg0_val);

    // Strobes decode straight from state and IR so async reset clears them at once.
    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign imm_we       = in_exec && (cls == OP_IMM);
    assign copy_we      = in_exec && (cls == OP_COPY);
    assign alu_start    = in_exec && (cls == OP_CALC);
    assign branch_taken = in_exec && (cls == OP_COND) && cond_take;
    assign imm_data     = {2'b00, ir_q[5:0]};
    assign copy_src     = ir_q[5:3];
    assign copy_dst     = ir_q[2:0];
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign busy         = (state_q != IDLE);
    assign fault        = fault_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            fault_q   <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run && !fault_q) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_data;
                        pc_q    <= pc_q + 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cls == OP_CALC) begin
                        tmo_cnt_q <= '0;
                        state_q   <= ALU_WAIT;
                    end else begin
                        if (branch_taken) begin
                            pc_q <= jump_target;
                        end
                        state_q <= run ? FETCH : IDLE;
                    end
                end
                ALU_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    // A completion in the timeout cycle still counts as success.
                    if (alu_done) begin
                        state_q <= run ? FETCH : IDLE;
                    end else if (tmo_cnt_inc >= CNT_W'(ALU_TIMEOUT)) begin
                        fault_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overture_sequencer.sv
// Scoreboard bench for overture_sequencer: a memory/register driver predicts each
// instruction's effects, a monitor checks them when the DUT executes.
module tb_overture_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] reg0_val;
    logic [7:0] reg3_val;
    logic       imm_we;
    logic [7:0] imm_data;
    logic       copy_we;
    logic [2:0] copy_src;
    logic [2:0] copy_dst;
    logic       alu_start;
    logic       alu_done;
    logic       branch_taken;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       busy;
    logic       fault;

    overture_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .ALU_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .reg0_val(reg0_val), .reg3_val(reg3_val),
        .imm_we(imm_we), .imm_data(imm_data), .copy_we(copy_we), .copy_src(copy_src),
        .copy_dst(copy_dst), .alu_start(alu_start), .alu_done(alu_done),
        .branch_taken(branch_taken), .pc(pc), .ir(ir), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] instr;
        bit         taken;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] prog[256];
    logic [7:0] reg0_tab[256];
    logic [7:0] reg3_tab[256];
    logic [7:0] model_pc;
    int         hs_count  = 0;
    int         fixed_dly = 2;
    int         forced_d  = 3;
    bit         alu_auto  = 1'b1;
    bit         noise_en  = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule for conditional jumps on a signed 8-bit operand.
    function automatic bit cond_true(input logic [2:0] c, input logic [7:0] raw);
        int v;
        v = (raw >= 8'd128) ? int'(raw) - 256 : int'(raw);
        case (c)
            3'd0: return 1'b0;
            3'd1: return v == 0;
            3'd2: return v < 0;
            3'd3: return v <= 0;
            3'd4: return 1'b1;
            3'd5: return v != 0;
            3'd6: return v >= 0;
            default: return v > 0;
        endcase
    endfunction

    // Instruction memory + register source; pushes the predicted outcome on every ack.
    initial begin
        bit   in_req;
        bit   hs_done;
        int   dly;
        exp_t e;
        in_req    = 1'b0;
        dly       = 0;
        model_pc  = 8'h00;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        reg0_val  = 8'h00;
        reg3_val  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                imem_ack = 1'b0;
                in_req   = 1'b0;
                model_pc = 8'h00;
                continue;
            end
            hs_done  = in_req && imem_ack;
            imem_ack = 1'b0;
            if (hs_done) in_req = 1'b0;
            if (imem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    dly    = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    e.addr    = model_pc;
                    e.instr   = prog[model_pc];
                    e.taken   = (e.instr[7:6] == 2'b11) && cond_true(e.instr[2:0], reg3_tab[model_pc]);
                    imem_ack  = 1'b1;
                    imem_data = prog[imem_addr];
                    reg0_val  = reg0_tab[model_pc];
                    reg3_val  = reg3_tab[model_pc];
                    exp_q.push_back(e);
                    model_pc  = e.taken ? reg0_tab[model_pc] : model_pc + 8'd1;
                    hs_count++;
                end else begin
                    dly--;
                end
            end else if (noise_en) begin
                imem_ack  = ($urandom_range(0, 3) == 0);
                imem_data = 8'($urandom);
            end
        end
    end

    // Monitor: the cycle after an accepted fetch is EXEC; compare it with the oldest prediction.
    initial begin
        bit         pend;
        logic [7:0] hs_addr;
        logic [7:0] nxt;
        logic [1:0] cls;
        exp_t       e;
        pend    = 1'b0;
        hs_addr = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("exec_without_prediction", 32'd1, 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    cls = e.instr[7:6];
                    nxt = e.addr + 8'd1;
                    check("fetch_addr", hs_addr, e.addr);
                    check("exec_ir", ir, e.instr);
                    check("exec_pc", pc, nxt);
                    check("exec_busy", busy, 1);
                    check("imm_we", imm_we, cls == 2'b00);
                    check("copy_we", copy_we, cls == 2'b10);
                    check("alu_start", alu_start, cls == 2'b01);
                    check("branch_taken", branch_taken, e.taken);
                    if (cls == 2'b00) check("imm_data", imm_data, {2'b00, e.instr[5:0]});
                    if (cls == 2'b10) begin
                        check("copy_src", copy_src, e.instr[5:3]);
                        check("copy_dst", copy_dst, e.instr[2:0]);
                    end
                end
            end else begin
                check("stray_strobe", {imm_we, copy_we, alu_start, branch_taken}, 4'b0000);
            end
            pend    = imem_req && imem_ack;
            hs_addr = imem_addr;
        end
    end

    // ALU model: answers each alu_start after 1..16 wait cycles, else injects ignored noise.
    initial begin
        int d;
        bit run_snap;
        alu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && alu_auto && alu_start) begin
                alu_done = 1'b0;
                d = (forced_d > 0) ? forced_d : int'($urandom_range(1, 16));
                repeat (d) @(negedge clk);
                alu_done = 1'b1;
                #3 run_snap = run;
                @(negedge clk);
                alu_done = 1'b0;
                #1;
                check("alu_resume_req", imem_req, run_snap);
                check("alu_no_fault", fault, 0);
            end else begin
                alu_done = (alu_auto && noise_en) ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    task automatic wait_hs(input int n, input int budget);
        int i = 0;
        while (hs_count < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("wait_fetch_count", 32'(hs_count >= n), 1);
    endtask

    task automatic wait_signal(input string name, input bit use_start, input int budget);
        int i = 0;
        bit seen = 1'b0;
        while (!seen && i < budget) begin
            @(negedge clk);
            #1;
            seen = use_start ? alu_start : imem_req;
            i++;
        end
        check(name, 32'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            prog[i] = 8'h00; reg0_tab[i] = 8'h00; reg3_tab[i] = 8'h00;
        end
        prog[8'h00] = 8'h2A;
        prog[8'h01] = 8'hC1; reg3_tab[8'h01] = 8'h00; reg0_tab[8'h01] = 8'h40;
        prog[8'h40] = 8'hC1; reg3_tab[8'h40] = 8'h01; reg0_tab[8'h40] = 8'h20;
        prog[8'h41] = 8'hC7; reg3_tab[8'h41] = 8'h80; reg0_tab[8'h41] = 8'h30;
        prog[8'h42] = 8'hC7; reg3_tab[8'h42] = 8'h7F; reg0_tab[8'h42] = 8'h50;
        prog[8'h50] = 8'hC0; reg3_tab[8'h50] = 8'h00; reg0_tab[8'h50] = 8'h10;
        prog[8'h51] = 8'hC4; reg3_tab[8'h51] = 8'h80; reg0_tab[8'h51] = 8'h60;
        prog[8'h60] = 8'h44;
        prog[8'h61] = 8'h9D;
        prog[8'h62] = 8'hC4; reg0_tab[8'h62] = 8'hFF;
        prog[8'hFF] = 8'h05;

        rst = 1'b1;
        run = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_imem_req", imem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 8'h00);
        check("rst_fault", fault, 0);

        // Reset asserted in the middle of a pending fetch.
        @(negedge clk);
        #2 rst = 1'b1;
        fixed_dly = 5;
        run = 1'b1;
        wait_signal("wait_fetch_req", 1'b0, 20);
        #1 rst = 1'b0;
        #1;
        check("midfetch_rst_req", imem_req, 0);
        check("midfetch_rst_pc", pc, 8'h00);
        check("midfetch_rst_busy", busy, 0);
        check("midfetch_rst_fault", fault, 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        fixed_dly = 2;

        // Directed program: imm, branches on each edge case, ALU, copy, PC wrap.
        wait_hs(11, 400);
        wait_signal("wait_refetch_req", 1'b0, 40);
        #1 run = 1'b0;
        wait_hs(12, 40);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("run_drop_busy", busy, 0);
        check("run_drop_req", imem_req, 0);
        check("run_drop_pc", pc, 8'h01);
        repeat (3) @(negedge clk);
        #1 check("run_drop_stays_idle", busy, 0);

        // ALU completion in the final allowed cycle, then a true timeout.
        prog[8'h01] = 8'h44;
        prog[8'h02] = 8'h44;
        forced_d = 16;
        #1 run = 1'b1;
        wait_hs(14, 200);
        alu_auto = 1'b0;
        wait_signal("wait_alu_start", 1'b1, 20);
        repeat (16) @(negedge clk);
        #1;
        check("tmo_last_cycle_fault", fault, 0);
        check("tmo_last_cycle_busy", busy, 1);
        @(negedge clk);
        #1;
        check("tmo_fault", fault, 1);
        check("tmo_idle", busy, 0);
        repeat (5) @(negedge clk);
        #1;
        check("fault_blocks_run", busy, 0);
        check("fault_blocks_req", imem_req, 0);
        check("fault_sticky", fault, 1);

        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_clears_fault", fault, 0);
        check("rst_clears_pc", pc, 8'h00);
        exp_q.delete();

        // Randomized program, register values, latencies, run toggling and noise.
        for (int i = 0; i < 256; i++) begin
            prog[i]     = 8'($urandom);
            reg0_tab[i] = 8'($urandom);
            case ($urandom_range(0, 4))
                0: reg3_tab[i] = 8'h00;
                1: reg3_tab[i] = 8'h80;
                2: reg3_tab[i] = 8'h7F;
                3: reg3_tab[i] = 8'hFF;
                default: reg3_tab[i] = 8'($urandom);
            endcase
        end
        fixed_dly = -1;
        forced_d  = 0;
        alu_auto  = 1'b1;
        noise_en  = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #2 run = ($urandom_range(0, 19) != 0);
        end
        run = 1'b0;
        begin
            int i = 0;
            while (busy && i < 60) begin
                @(negedge clk);
                #1;
                i++;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check("final_idle", busy, 0);
        check("final_no_fault", fault, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
